// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - control word layout and bubble pattern for the MIPS pipeline
//
// Purpose: width of the decoder control word, bit offsets of each control
// field, and the NOP-safe bubble pattern loaded on reset/flush/bubble.
// Ports: none (package).
package ctrl_pkg;

  localparam int CTRL_W = 20;

  // Single-bit field offsets inside the control word
  localparam int JUMP           = 0;
  localparam int BRANCH_E       = 1;
  localparam int BRANCH_NE      = 2;
  localparam int REGDEST        = 3;
  localparam int MEMREAD        = 4;
  localparam int MEMWRITE       = 5;
  localparam int MEMTOREG       = 6;
  localparam int ALUSRC         = 7;
  localparam int REGWRITE       = 8;
  // ALUOP occupies [ALUOP +: ALUOP_W]
  localparam int ALUOP          = 9;
  localparam int ALUOP_W        = 4;
  localparam int IS_SIGN        = 13;
  localparam int ZERO_EXT       = 14;
  localparam int USE_SA         = 15;
  localparam int ALU_SIGN_RESET = 16;

  // Builds the bubble: nothing writes anything, ALU left in signed/reset mode.
  function automatic logic [CTRL_W-1:0] make_bubble();
    logic [CTRL_W-1:0] w;
    w                 = '0;
    w[IS_SIGN]        = 1'b1;
    w[ALU_SIGN_RESET] = 1'b1;
    return w;
  endfunction

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = make_bubble();

endpackage

// File: rtl/ctrl_pipe_stage.sv
// rtl/ctrl_pipe_stage.sv - one control pipeline stage with hold/flush/bubble
//
// Purpose: data + valid register for one pipeline boundary and its
// next-state priority mux (flush > hold > upstream-hold bubble > advance).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush_i           load bubble, clear valid (overrides hold)
//   hold_i            keep current contents
//   up_hold_i         upstream stage frozen: take a bubble
//   prev_data_i       word offered by the previous stage (or decoder)
//   prev_valid_i      valid of the offered word
//   data_o, valid_o   registered stage contents
module ctrl_pipe_stage
  import ctrl_pkg::*;
#(
  parameter int               WIDTH      = CTRL_W,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = CTRL_BUBBLE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             hold_i,
  input  logic             up_hold_i,
  input  logic [WIDTH-1:0] prev_data_i,
  input  logic             prev_valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush_i) begin
      data_d  = BUBBLE_VAL;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      // An invalid word is always replaced by the bubble so that in_data
      // garbage never enters the pipe when in_valid is low.
      if (up_hold_i || !prev_valid_i) begin
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end else begin
        data_d  = prev_data_i;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= BUBBLE_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe_reg.sv
// rtl/ctrl_pipe_reg.sv - DEPTH-stage control-word pipeline with stall/flush
//
// Purpose: chain of DEPTH ctrl_pipe_stage instances between decoder and
// EX/MEM/WB, with the downstream-to-upstream hold OR-chain.
// Optional: define CTRL_PIPE_PERF_EN to add stall_cnt/bubble_cnt counters.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   in_data, in_valid      control word from decoder and its valid
//   in_ready               stage 0 accepts this cycle (combinational from stall)
//   stall[DEPTH]           per-stage stall request
//   flush[DEPTH]           per-stage bubble insert
//   stage_data, stage_valid  all stage contents, stage i at [i*WIDTH +: WIDTH]
//   out_data, out_valid    last stage contents
//   stall_cnt, bubble_cnt  saturating perf counters (CTRL_PIPE_PERF_EN only)
module ctrl_pipe_reg
  import ctrl_pkg::*;
#(
  parameter int               WIDTH      = CTRL_W,
  parameter int               DEPTH      = 3,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = CTRL_BUBBLE
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            bubble_cnt
`endif
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] up_hold;
  logic [DEPTH-1:0] prev_valid;
  logic [WIDTH-1:0] prev_data [DEPTH];
  logic [WIDTH-1:0] sdata     [DEPTH];

  // A stalled stage freezes everything upstream of it.
  always_comb begin
    hold            = '0;
    hold[DEPTH-1]   = stall[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      hold[i] = stall[i] | hold[i+1];
    end
  end

  assign in_ready = ~hold[0];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign prev_data[i]  = in_data;
      assign prev_valid[i] = in_valid;
      assign up_hold[i]    = 1'b0;
    end else begin : g_rest
      assign prev_data[i]  = sdata[i-1];
      assign prev_valid[i] = stage_valid[i-1];
      assign up_hold[i]    = hold[i-1];
    end

    ctrl_pipe_stage #(
      .WIDTH      (WIDTH),
      .BUBBLE_VAL (BUBBLE_VAL)
    ) u_stage (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush_i      (flush[i]),
      .hold_i       (hold[i]),
      .up_hold_i    (up_hold[i]),
      .prev_data_i  (prev_data[i]),
      .prev_valid_i (prev_valid[i]),
      .data_o       (sdata[i]),
      .valid_o      (stage_valid[i])
    );

    assign stage_data[i*WIDTH +: WIDTH] = sdata[i];
  end

  assign out_data  = sdata[DEPTH-1];
  assign out_valid = stage_valid[DEPTH-1];

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;
  logic        last_cap_invalid;

  // Last stage loads something this edge (not held, or flushed) and what it
  // loads is not a valid instruction.
  assign last_cap_invalid = flush[DEPTH-1] |
                            (~hold[DEPTH-1] & (up_hold[DEPTH-1] | ~prev_valid[DEPTH-1]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (hold[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (last_cap_invalid && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// tb/tb_ctrl_pipe_reg.sv - directed self-checking bench for ctrl_pipe_reg
module tb_ctrl_pipe_reg;

  localparam int W = 20;
  localparam int D = 3;
  localparam logic [W-1:0] BUB = 20'h12000;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic [D-1:0]   stall;
  logic [D-1:0]   flush;
  logic [D*W-1:0] stage_data;
  logic [D-1:0]   stage_valid;
  logic [W-1:0]   out_data;
  logic           out_valid;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]    stall_cnt;
  logic [31:0]    bubble_cnt;
`endif

  int checks;
  int errors;

  ctrl_pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .stage_data  (stage_data),
    .stage_valid (stage_valid),
    .out_data    (out_data),
    .out_valid   (out_valid)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sd(input int i);
    return stage_data[i*W +: W];
  endfunction

  // Advance one edge; inputs applied afterwards affect the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d, input logic v);
    in_data  = d;
    in_valid = v;
    step();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b1;
    in_data  = '0;
    in_valid = 1'b0;
    stall    = '0;
    flush    = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", {29'd0, stage_valid}, 32'd0);
    check("rst_s0", {12'd0, sd(0)}, {12'd0, BUB});
    check("rst_s2", {12'd0, sd(2)}, {12'd0, BUB});
    check("rst_out", {12'd0, out_data}, {12'd0, BUB});
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: single word latency of 3
    push(20'h0ABCD, 1'b1);
    in_valid = 1'b0;
    check("lat_e1_s0", {12'd0, sd(0)}, 32'h0ABCD);
    step();
    check("lat_e2_outv", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_e3_out", {12'd0, out_data}, 32'h0ABCD);
    check("lat_e3_outv", {31'd0, out_valid}, 32'd1);
    step();
    check("lat_e4_out", {12'd0, out_data}, {12'd0, BUB});
    check("lat_e4_outv", {31'd0, out_valid}, 32'd0);

    // 2: stream 1..4 with stall[1] for 2 cycles while word 2 sits in stage 1
    push(20'd1, 1'b1);
    push(20'd2, 1'b1);
    push(20'd3, 1'b1);
    check("st_pre_out", {12'd0, out_data}, 32'd1);
    in_data = 20'd4;
    stall   = 3'b010;
    #1;
    check("st_in_ready", {31'd0, in_ready}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      check("st_s0_hold", {12'd0, sd(0)}, 32'd3);
      check("st_s1_hold", {12'd0, sd(1)}, 32'd2);
      check("st_s2_bub", {12'd0, sd(2)}, {12'd0, BUB});
      check("st_valid", {29'd0, stage_valid}, 32'b011);
    end
    stall = 3'b000;
    step();
    check("st_f_out", {12'd0, out_data}, 32'd2);
    check("st_f_s0", {12'd0, sd(0)}, 32'd4);
    in_valid = 1'b0;
    step();
    check("st_g_out", {12'd0, out_data}, 32'd3);
    step();
    check("st_h_out", {12'd0, out_data}, 32'd4);
    check("st_h_valid", {29'd0, stage_valid}, 32'b100);

    // downstream stall backs up all stages
    stall = 3'b100;
    #1;
    check("chain_in_ready", {31'd0, in_ready}, 32'd0);
    stall = 3'b000;

    // 3: flush 011 with stall 001
    push(20'h11, 1'b1);
    push(20'h22, 1'b1);
    push(20'h33, 1'b1);
    in_data = 20'h44;
    stall   = 3'b001;
    flush   = 3'b011;
    #1;
    check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    stall = '0;
    flush = '0;
    check("fl_s0", {12'd0, sd(0)}, {12'd0, BUB});
    check("fl_s1", {12'd0, sd(1)}, {12'd0, BUB});
    check("fl_s2", {12'd0, sd(2)}, 32'h22);
    check("fl_valid", {29'd0, stage_valid}, 32'b100);

    // flush and stall on the same stage: flush wins
    stall = 3'b100;
    flush = 3'b100;
    in_valid = 1'b0;
    step();
    stall = '0;
    flush = '0;
    check("fl_st_same_v", {31'd0, out_valid}, 32'd0);
    check("fl_st_same_d", {12'd0, out_data}, {12'd0, BUB});

    // 4: async reset mid-cycle with all stages valid
    push(20'h55, 1'b1);
    push(20'h66, 1'b1);
    push(20'h77, 1'b1);
    in_valid = 1'b0;
    check("ar_pre_valid", {29'd0, stage_valid}, 32'b111);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", {29'd0, stage_valid}, 32'd0);
    check("ar_s0", {12'd0, sd(0)}, {12'd0, BUB});
    check("ar_s1", {12'd0, sd(1)}, {12'd0, BUB});
    check("ar_s2", {12'd0, sd(2)}, {12'd0, BUB});
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 5: invalid input never captured
    push(20'h00123, 1'b1);
    push(20'hFFFFF, 1'b0);
    check("inv_s0", {12'd0, sd(0)}, {12'd0, BUB});
    check("inv_s0_v", {31'd0, stage_valid[0]}, 32'd0);
    check("inv_s1", {12'd0, sd(1)}, 32'h00123);

`ifdef CTRL_PIPE_PERF_EN
    // 6: perf counters from an empty pipe
    do_reset();
    check("perf_rst_stall", stall_cnt, 32'd0);
    stall = 3'b001;
    for (int c = 0; c < 5; c++) step();
    stall = '0;
    check("perf_stall_cnt", stall_cnt, 32'd5);
    check("perf_bubble_cnt", bubble_cnt, 32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
